// File: rtl/eth_tx_arb.sv
// Two-source round-robin frame arbiter feeding the 10G MAC, with a fixed inter-frame gap.
// Define ETH_TX_ARB_STATS_EN to add per-source completed-frame counters.
module eth_tx_arb #(
   parameter int unsigned IFG_CYCLES = 2,
   parameter int unsigned STATS_W    = 32
) (
   input  logic        eth_clk,
   input  logic        eth_rst,

   input  logic        s0_tvalid,
   output logic        s0_tready,
   input  logic [63:0] s0_tdata,
   input  logic [7:0]  s0_tkeep,
   input  logic        s0_tlast,
   input  logic        s0_tuser,

   input  logic        s1_tvalid,
   output logic        s1_tready,
   input  logic [63:0] s1_tdata,
   input  logic [7:0]  s1_tkeep,
   input  logic        s1_tlast,
   input  logic        s1_tuser,

   output logic        eth_tx_tvalid,
   input  logic        eth_tx_tready,
   output logic [63:0] eth_tx_tdata,
   output logic [7:0]  eth_tx_tkeep,
   output logic        eth_tx_tlast,
   output logic        eth_tx_tuser
`ifdef ETH_TX_ARB_STATS_EN
   ,
   output logic [STATS_W-1:0] stat_frames0,
   output logic [STATS_W-1:0] stat_frames1
`endif
);

   if (STATS_W < 1 || IFG_CYCLES > 255) begin : g_param_check
      $error("eth_tx_arb: STATS_W must be >= 1 and IFG_CYCLES <= 255");
   end

   typedef enum logic [1:0] {StIdle, StGrant0, StGrant1, StGap} state_t;

   // Counter is loaded with IFG_CYCLES-1 so GAP lasts exactly IFG_CYCLES cycles.
   localparam logic [7:0] IfgLoad = (IFG_CYCLES > 0) ? 8'(IFG_CYCLES - 1) : 8'd0;

   state_t     state_q;
   logic [7:0] gap_cnt_q;
   logic       last_q;
   logic       end0;
   logic       end1;

   assign end0 = (state_q == StGrant0) && s0_tvalid && eth_tx_tready && s0_tlast;
   assign end1 = (state_q == StGrant1) && s1_tvalid && eth_tx_tready && s1_tlast;

   always_ff @(posedge eth_clk or negedge eth_rst) begin
      if (!eth_rst) begin
         state_q   <= StIdle;
         gap_cnt_q <= 8'd0;
         last_q    <= 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               // On a tie, serve the source that did not go last.
               if (s0_tvalid && (!s1_tvalid || last_q)) state_q <= StGrant0;
               else if (s1_tvalid)                       state_q <= StGrant1;
            end
            StGrant0: begin
               if (end0) begin
                  last_q <= 1'b0;
                  if (IFG_CYCLES > 0) begin
                     state_q   <= StGap;
                     gap_cnt_q <= IfgLoad;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StGrant1: begin
               if (end1) begin
                  last_q <= 1'b1;
                  if (IFG_CYCLES > 0) begin
                     state_q   <= StGap;
                     gap_cnt_q <= IfgLoad;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StGap: begin
               if (gap_cnt_q == 8'd0) state_q   <= StIdle;
               else                   gap_cnt_q <= gap_cnt_q - 8'd1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      eth_tx_tvalid = 1'b0;
      eth_tx_tdata  = 64'd0;
      eth_tx_tkeep  = 8'd0;
      eth_tx_tlast  = 1'b0;
      eth_tx_tuser  = 1'b0;
      s0_tready     = 1'b0;
      s1_tready     = 1'b0;
      case (state_q)
         StGrant0: begin
            eth_tx_tvalid = s0_tvalid;
            eth_tx_tdata  = s0_tdata;
            eth_tx_tkeep  = s0_tkeep;
            eth_tx_tlast  = s0_tlast;
            eth_tx_tuser  = s0_tuser;
            s0_tready     = eth_tx_tready;
         end
         StGrant1: begin
            eth_tx_tvalid = s1_tvalid;
            eth_tx_tdata  = s1_tdata;
            eth_tx_tkeep  = s1_tkeep;
            eth_tx_tlast  = s1_tlast;
            eth_tx_tuser  = s1_tuser;
            s1_tready     = eth_tx_tready;
         end
         default: ;
      endcase
   end

`ifdef ETH_TX_ARB_STATS_EN
   logic [STATS_W-1:0] frames0_q;
   logic [STATS_W-1:0] frames1_q;

   always_ff @(posedge eth_clk or negedge eth_rst) begin
      if (!eth_rst) begin
         frames0_q <= '0;
         frames1_q <= '0;
      end else begin
         if (end0) frames0_q <= frames0_q + 1'b1;
         if (end1) frames1_q <= frames1_q + 1'b1;
      end
   end

   assign stat_frames0 = frames0_q;
   assign stat_frames1 = frames1_q;
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: per-cycle vector table plus frame-level corner sequences.
module tb_eth_tx_arb;

   localparam int unsigned StatsW = 4;

   logic        eth_clk = 1'b0;
   logic        eth_rst;
   logic        s0_tvalid, s0_tready, s0_tlast, s0_tuser;
   logic [63:0] s0_tdata;
   logic [7:0]  s0_tkeep;
   logic        s1_tvalid, s1_tready, s1_tlast, s1_tuser;
   logic [63:0] s1_tdata;
   logic [7:0]  s1_tkeep;
   logic        eth_tx_tvalid, eth_tx_tready, eth_tx_tlast, eth_tx_tuser;
   logic [63:0] eth_tx_tdata;
   logic [7:0]  eth_tx_tkeep;
`ifdef ETH_TX_ARB_STATS_EN
   logic [StatsW-1:0] stat_frames0, stat_frames1;
`endif

   int checks = 0;
   int errors = 0;

   always #5 eth_clk = ~eth_clk;

   eth_tx_arb #(.IFG_CYCLES(2), .STATS_W(StatsW)) dut (
      .eth_clk       (eth_clk),
      .eth_rst       (eth_rst),
      .s0_tvalid     (s0_tvalid),
      .s0_tready     (s0_tready),
      .s0_tdata      (s0_tdata),
      .s0_tkeep      (s0_tkeep),
      .s0_tlast      (s0_tlast),
      .s0_tuser      (s0_tuser),
      .s1_tvalid     (s1_tvalid),
      .s1_tready     (s1_tready),
      .s1_tdata      (s1_tdata),
      .s1_tkeep      (s1_tkeep),
      .s1_tlast      (s1_tlast),
      .s1_tuser      (s1_tuser),
      .eth_tx_tvalid (eth_tx_tvalid),
      .eth_tx_tready (eth_tx_tready),
      .eth_tx_tdata  (eth_tx_tdata),
      .eth_tx_tkeep  (eth_tx_tkeep),
      .eth_tx_tlast  (eth_tx_tlast),
      .eth_tx_tuser  (eth_tx_tuser)
`ifdef ETH_TX_ARB_STATS_EN
      ,
      .stat_frames0  (stat_frames0),
      .stat_frames1  (stat_frames1)
`endif
   );

   // sel: 0 = all-zero output, 1 = s0 passed through, 2 = s1 passed through
   typedef struct {
      logic       rst, rdy;
      logic       v0; logic [7:0] d0; logic l0, u0;
      logic       v1; logic [7:0] d1; logic l1, u1;
      logic       ev, el, eu; logic [1:0] sel; logic er0, er1;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      s0_tvalid = 0; s0_tdata = '0; s0_tlast = 0; s0_tuser = 0;
      s1_tvalid = 0; s1_tdata = '0; s1_tlast = 0; s1_tuser = 0;
   endtask

   task automatic do_reset();
      @(negedge eth_clk);
      idle_inputs();
      eth_tx_tready = 1;
      eth_rst = 0;
      @(negedge eth_clk);
      eth_rst = 1;
   endtask

   // Sends an n-beat s1 frame (tdata = beat index) and checks what the MAC side accepts.
   task automatic run_s1_frame(input string name, input int n, input bit rand_rdy);
      logic [63:0] got[$];
      int          last_pos = -1;
      int          idx = 0;
      bit          s0_rdy_seen = 0;
      bit          done = 0;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         @(negedge eth_clk);
         s1_tvalid     = (idx < n);
         s1_tdata      = 64'(idx);
         s1_tlast      = (idx == n - 1);
         eth_tx_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         #4;
         if (s0_tready) s0_rdy_seen = 1;
         if (eth_tx_tvalid && eth_tx_tready) begin
            got.push_back(eth_tx_tdata);
            if (eth_tx_tlast) begin
               last_pos = got.size() - 1;
               done     = 1;
            end
            idx++;
         end
      end
      @(negedge eth_clk);
      idle_inputs();
      eth_tx_tready = 1;
      chk({name, " beats"}, 128'(got.size()), 128'(n));
      chk({name, " tlast_pos"}, 128'(last_pos), 128'(n - 1));
      chk({name, " s0_tready"}, 128'(s0_rdy_seen), 128'(0));
      for (int i = 0; i < got.size(); i++)
         chk($sformatf("%s data[%0d]", name, i), 128'(got[i]), 128'(i));
   endtask

   task automatic add(input logic rst, rdy, v0, input logic [7:0] d0, input logic l0, u0,
                      input logic v1, input logic [7:0] d1, input logic l1, u1,
                      input logic ev, el, eu, input logic [1:0] sel, input logic er0, er1);
      vec_t v;
      v = '{rst, rdy, v0, d0, l0, u0, v1, d1, l1, u1, ev, el, eu, sel, er0, er1};
      vecs.push_back(v);
   endtask

   initial begin
      eth_rst = 0;
      eth_tx_tready = 1;
      s0_tkeep = 8'hFF;
      s1_tkeep = 8'h0F;
      idle_inputs();

      //  rst rdy  v0 d0    l0 u0  v1 d1    l1 u1  ev el eu sel r0 r1
      add(0, 1,   0, 8'h00, 0, 0,  0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0);
      // 3-beat s0 frame, then the 2-cycle gap
      add(1, 1,   1, 8'hA0, 0, 0,  0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   1, 8'hA0, 0, 0,  0, 8'h00, 0, 0,  1, 0, 0, 1, 1, 0);
      add(1, 1,   1, 8'hA1, 0, 0,  0, 8'h00, 0, 0,  1, 0, 0, 1, 1, 0);
      add(1, 1,   1, 8'hA2, 1, 0,  0, 8'h00, 0, 0,  1, 1, 0, 1, 1, 0);
      add(1, 1,   0, 8'h00, 0, 0,  0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   0, 8'h00, 0, 0,  0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   0, 8'h00, 0, 0,  0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0);
      // reset, then a tie: s0 first, s1 next, next tie back to s0
      add(0, 1,   1, 8'hC0, 0, 0,  1, 8'hD0, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   1, 8'hC0, 0, 0,  1, 8'hD0, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   1, 8'hC0, 0, 0,  1, 8'hD0, 0, 0,  1, 0, 0, 1, 1, 0);
      add(1, 1,   1, 8'hC1, 1, 0,  1, 8'hD0, 0, 0,  1, 1, 0, 1, 1, 0);
      add(1, 1,   1, 8'hE0, 1, 0,  1, 8'hD0, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   1, 8'hE0, 1, 0,  1, 8'hD0, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   1, 8'hE0, 1, 0,  1, 8'hD0, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   1, 8'hE0, 1, 0,  1, 8'hD0, 0, 0,  1, 0, 0, 2, 0, 1);
      add(1, 1,   1, 8'hE0, 1, 0,  1, 8'hD1, 1, 1,  1, 1, 1, 2, 0, 1);
      add(1, 1,   1, 8'hE0, 1, 0,  1, 8'hF0, 1, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   1, 8'hE0, 1, 0,  1, 8'hF0, 1, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   1, 8'hE0, 1, 0,  1, 8'hF0, 1, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   1, 8'hE0, 1, 0,  1, 8'hF0, 1, 0,  1, 1, 0, 1, 1, 0);
      // s0 tvalid drops mid-frame while s1 waits
      add(1, 1,   1, 8'h30, 0, 0,  0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   1, 8'h30, 0, 0,  0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   1, 8'h30, 0, 0,  0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   1, 8'h30, 0, 0,  1, 8'hF0, 1, 0,  1, 0, 0, 1, 1, 0);
      for (int i = 0; i < 4; i++)
         add(1, 1, 0, 8'h31, 0, 0,  1, 8'hF0, 1, 0,  0, 0, 0, 1, 1, 0);
      add(1, 1,   1, 8'h31, 1, 0,  1, 8'hF0, 1, 0,  1, 1, 0, 1, 1, 0);
      add(1, 1,   0, 8'h00, 0, 0,  1, 8'hF0, 1, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   0, 8'h00, 0, 0,  1, 8'hF0, 1, 0,  0, 0, 0, 0, 0, 0);
      add(1, 1,   0, 8'h00, 0, 0,  1, 8'hF0, 1, 0,  0, 0, 0, 0, 0, 0);
      // single-beat s1 frame stalled one cycle by the MAC
      add(1, 0,   0, 8'h00, 0, 0,  1, 8'hF0, 1, 0,  1, 1, 0, 2, 0, 0);
      add(1, 1,   0, 8'h00, 0, 0,  1, 8'hF0, 1, 0,  1, 1, 0, 2, 0, 1);
      add(1, 1,   0, 8'h00, 0, 0,  0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         logic [63:0] ed;
         logic [7:0]  ek;
         @(negedge eth_clk);
         eth_rst       = vecs[i].rst;
         eth_tx_tready = vecs[i].rdy;
         s0_tvalid = vecs[i].v0; s0_tdata = {8{vecs[i].d0}};
         s0_tlast  = vecs[i].l0; s0_tuser = vecs[i].u0;
         s1_tvalid = vecs[i].v1; s1_tdata = {8{vecs[i].d1}};
         s1_tlast  = vecs[i].l1; s1_tuser = vecs[i].u1;
         #4;
         ed = (vecs[i].sel == 1) ? s0_tdata : (vecs[i].sel == 2) ? s1_tdata : 64'd0;
         ek = (vecs[i].sel == 1) ? s0_tkeep : (vecs[i].sel == 2) ? s1_tkeep : 8'd0;
         chk($sformatf("vec[%0d]", i),
             128'({eth_tx_tvalid, eth_tx_tlast, eth_tx_tuser, eth_tx_tdata, eth_tx_tkeep,
                   s0_tready, s1_tready}),
             128'({vecs[i].ev, vecs[i].el, vecs[i].eu, ed, ek, vecs[i].er0, vecs[i].er1}));
      end

      // 8-beat s1 frame under random backpressure
      do_reset();
      run_s1_frame("rand_rdy", 8, 1'b1);

      // reset pulsed at beat 2 of a 5-beat s0 frame
      do_reset();
      s0_tdata = 64'h55;
      s0_tvalid = 1;
      for (int b = 0; b < 3; b++) begin
         @(negedge eth_clk);
         s0_tdata = 64'(b);
      end
      #1;
      chk("beat2_presented", 128'({eth_tx_tvalid, eth_tx_tdata}), 128'({1'b1, 64'd2}));
      eth_rst = 0;
      #1;
      chk("rst_mid_frame_zero",
          128'({eth_tx_tvalid, eth_tx_tlast, eth_tx_tuser, eth_tx_tdata, eth_tx_tkeep,
                s0_tready, s1_tready}), 128'(0));
      @(negedge eth_clk);
      eth_rst = 1;
      idle_inputs();
      run_s1_frame("after_rst", 3, 1'b0);

`ifdef ETH_TX_ARB_STATS_EN
      begin
         int n = 0;
         do_reset();
         #4;
         chk("stats_reset", 128'({stat_frames0, stat_frames1}), 128'(0));
         s0_tvalid = 1;
         s0_tlast  = 1;
         for (int cyc = 0; cyc < 200 && n < 17; cyc++) begin
            @(negedge eth_clk);
            #4;
            if (eth_tx_tvalid && eth_tx_tready && eth_tx_tlast && s0_tready) n++;
         end
         chk("stats_frames_sent", 128'(n), 128'(17));
         @(negedge eth_clk);
         idle_inputs();
         #4;
         chk("stat_frames0_wrap", 128'(stat_frames0), 128'(1));
         chk("stat_frames1", 128'(stat_frames1), 128'(0));
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
